// File: rtl/reg_file_pkg.sv
// Shared types and default geometry for the reg_file block.
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/reg_n.sv
// Single storage entry: WIDTH-bit register with load enable and synchronous clear.
module reg_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // No reset: contents are defined by the clear sequence, not by rst.
  always_ff @(posedge clk) begin
    if (clr)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with a sequential bulk-clear controller.
// Optional macro REG_FILE_BYPASS_EN forwards accepted write data to matching reads.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              clr_req,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              busy
);

  state_t                        state;
  logic [ADDR_W-1:0]             clr_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]   q;
  logic [DEPTH-1:0]              ld;
  logic [DEPTH-1:0]              clr;
  logic                          idle_wr;
  logic                          wr_ok;
  logic [WIDTH-1:0]              rd_a;
  logic [WIDTH-1:0]              rd_b;

  assign busy    = (state == CLEAR);
  assign idle_wr = rst && !busy && we && !clr_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr == ADDR_W'(DEPTH-1)) begin
            state   <= IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Address decode doubles as the range check: out-of-range addresses hit no entry.
  always_comb begin
    ld  = '0;
    clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ld[i]  = idle_wr && (waddr == ADDR_W'(i));
      clr[i] = rst && busy && (clr_ptr == ADDR_W'(i));
    end
  end

  assign wr_ok = |ld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    reg_n #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .ld  (ld[i]),
      .clr (clr[i]),
      .d   (wdata),
      .q   (q[i])
    );
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == ADDR_W'(i)) rd_a = q[i];
      if (raddr_b == ADDR_W'(i)) rd_b = q[i];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_ok && (raddr_a == waddr)) rd_a = wdata;
    if (wr_ok && (raddr_b == waddr)) rd_b = wdata;
`endif
  end

  // Busy masking sits after the bypass so it always wins.
  assign rdata_a = busy ? '0 : rd_a;
  assign rdata_b = busy ? '0 : rd_b;

`ifndef REG_FILE_BYPASS_EN
  logic unused_wr_ok;
  assign unused_wr_ok = wr_ok;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed bench for reg_file, DEPTH=8 and DEPTH=6 instances on shared inputs.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        clr_req = 1'b0;
  logic [2:0]  waddr = '0;
  logic [2:0]  raddr_a = '0;
  logic [2:0]  raddr_b = '0;
  logic [15:0] wdata = '0;
  logic [15:0] ra8, rb8, ra6, rb6;
  logic        busy8, busy6;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file #(.WIDTH(16), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr_req(clr_req),
    .rdata_a(ra8), .rdata_b(rb8), .busy(busy8)
  );

  reg_file #(.WIDTH(16), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .clr_req(clr_req),
    .rdata_a(ra6), .rdata_b(rb6), .busy(busy6)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  int          dep [2] = '{8, 6};
  int          left [2] = '{0, 0};   // edges until clear finishes
  logic [15:0] mem [2][8];
  bit          live = 1'b0;
  int          n;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [15:0] exp_rd(input int k, input logic [2:0] ra);
    if (left[k] > 0 || int'(ra) >= dep[k]) return 16'h0;
    if (BYP && rst && we && !clr_req && waddr == ra && int'(waddr) < dep[k]) return wdata;
    return mem[k][ra];
  endfunction

  // One clock: check settled outputs against the model, then apply the edge to the model.
  task automatic cyc();
    #2;
    if (live) begin
      chk("busy8", 16'(busy8), 16'(left[0] > 0));
      chk("busy6", 16'(busy6), 16'(left[1] > 0));
      chk("rd_a8", ra8, exp_rd(0, raddr_a));
      chk("rd_b8", rb8, exp_rd(0, raddr_b));
      chk("rd_a6", ra6, exp_rd(1, raddr_a));
      chk("rd_b6", rb6, exp_rd(1, raddr_b));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) left[k] = dep[k];
      else if (left[k] > 0) begin
        mem[k][dep[k] - left[k]] = 16'h0;
        left[k]--;
      end else if (clr_req) left[k] = dep[k];
      else if (we && int'(waddr) < dep[k]) mem[k][waddr] = wdata;
    end
    live = live || !rst;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 8; a++) mem[k][a] = 16'h0;
    @(posedge clk); #1;

    // reset, then measure clear length
    rst = 1'b0; cyc(); cyc();
    rst = 1'b1;
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin cyc(); n++; end
    chk("rst_busy_len", 16'(n), 16'd8);
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(7 - a); cyc();
    end

    // basic write then dual read
    we = 1'b1; waddr = 3'd3; wdata = 16'hA5A5; raddr_a = 3'd0; cyc();
    we = 1'b0; raddr_a = 3'd3; raddr_b = 3'd3;
    #2;
    chk("a5_port_a", ra8, 16'hA5A5);
    chk("a5_port_b", rb8, 16'hA5A5);
    cyc();
    raddr_a = 3'd2; cyc();

    // same-cycle read of a written address
    we = 1'b1; waddr = 3'd5; wdata = 16'h1234; raddr_a = 3'd5;
    #2;
    chk("byp_same", ra8, BYP ? 16'h1234 : 16'h0000);
    cyc();
    we = 1'b0;
    #2;
    chk("byp_next", ra8, 16'h1234);
    cyc();

    // fill, then clear colliding with a write; random write/clr pulses while busy
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 16'($urandom); cyc();
    end
    we = 1'b1; waddr = 3'd1; wdata = 16'hFFFF; clr_req = 1'b1; cyc();
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin
      we = 1'($urandom); waddr = 3'($urandom); wdata = 16'($urandom);
      clr_req = 1'($urandom);
      cyc(); n++;
    end
    chk("clr_busy_len", 16'(n), 16'd8);
    we = 1'b0; clr_req = 1'b0;
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a); raddr_b = 3'(a); cyc();
      chk("clr_zero8", ra8, 16'h0);
    end

    // reset in the middle of a clear restarts it
    clr_req = 1'b1; cyc();
    clr_req = 1'b0;
    repeat (4) cyc();
    rst = 1'b0; cyc();
    rst = 1'b1;
    n = 0;
    while (busy8 === 1'b1 && n < 20) begin cyc(); n++; end
    chk("midclr_rst_len", 16'(n), 16'd8);

    // out-of-range write on the DEPTH=6 instance
    for (int a = 0; a < 6; a++) begin
      we = 1'b1; waddr = 3'(a); wdata = 16'(16'h100 + a); cyc();
    end
    we = 1'b1; waddr = 3'd7; wdata = 16'hBEEF; cyc();
    we = 1'b0; raddr_a = 3'd7;
    #2;
    chk("d6_oob_rd", ra6, 16'h0);
    chk("d8_addr7", ra8, 16'hBEEF);
    cyc();
    for (int a = 0; a < 6; a++) begin
      raddr_b = 3'(a); cyc();
      chk("d6_keep", rb6, 16'(16'h100 + a));
    end

    // random traffic
    repeat (400) begin
      rst     = ($urandom % 64) != 0;
      we      = 1'($urandom);
      clr_req = ($urandom % 24) == 0;
      waddr   = 3'($urandom);
      wdata   = 16'($urandom);
      raddr_a = ($urandom % 3 == 0) ? waddr : 3'($urandom);
      raddr_b = 3'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
